// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants, state enum and helpers for the SPI listeners
package spi_pkg;

  localparam logic [7:0]  HDR_VAL_CMD      = 8'h00;
  localparam logic [7:0]  HDR_VAL_STATUS   = 8'h20;
  localparam logic [7:0]  HDR_MASK_DEFAULT = 8'hE0;
  localparam logic [15:0] TIMEOUT_DEFAULT  = 16'd400;

  typedef enum logic {
    IDLE,
    COLLECT
  } state_e;

  function automatic int ch_width(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/spi_frame_listener_if.sv
// rtl/spi_frame_listener_if.sv - byte input and frame output bundle of the frame listener
interface spi_frame_listener_if
  import spi_pkg::*;
#(
  parameter int FRAME_BYTES = 3,
  parameter int NUM_CH      = 4
);
  localparam int CH_W = ch_width(NUM_CH);

  logic                     spi_slave_data_valid;
  logic [7:0]               spi_slave_byte;
  logic [8*FRAME_BYTES-1:0] frame_data;
  logic [CH_W-1:0]          frame_ch;
  logic                     frame_valid;
  logic [NUM_CH-1:0]        ch_irq;
  logic                     timeout_err;
  logic                     chk_err;

  modport master (
    output spi_slave_data_valid, spi_slave_byte,
    input  frame_data, frame_ch, frame_valid, ch_irq, timeout_err, chk_err
  );

  modport slave (
    input  spi_slave_data_valid, spi_slave_byte,
    output frame_data, frame_ch, frame_valid, ch_irq, timeout_err, chk_err
  );

endinterface

// File: rtl/spi_idle_timer.sv
// rtl/spi_idle_timer.sv - 16-bit idle counter with clear/enable, flags when it reaches LIMIT
module spi_idle_timer
  import spi_pkg::*;
#(
  parameter logic [15:0] LIMIT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] count_q, count_d;

  assign expired = (count_q == LIMIT);

  // Saturate at LIMIT so a late abort can never see the counter wrap.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expired) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/spi_frame_listener.sv
// rtl/spi_frame_listener.sv - assembles header-matched frames from SPI bytes and routes them to channel irqs
module spi_frame_listener
  import spi_pkg::*;
#(
  parameter int         FRAME_BYTES    = 3,
  parameter logic [7:0] HDR_VAL        = HDR_VAL_CMD,
  parameter logic [7:0] HDR_MASK       = HDR_MASK_DEFAULT,
  parameter int         TIMEOUT_CYCLES = int'(TIMEOUT_DEFAULT),
  parameter int         NUM_CH         = 4,
  parameter int         CH_LSB         = 0,
  parameter bit         CHK_EN         = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_frame_listener_if.slave   bus
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int FW    = 8 * FRAME_BYTES;
  localparam int CNT_W = 5;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        xor_q, xor_d;
  logic [FW-1:0]     buf_q, buf_d;
  logic [FW-1:0]     frame_data_q, frame_data_d;
  logic [CH_W-1:0]   frame_ch_q, frame_ch_d;
  logic              frame_valid_q, frame_valid_d;
  logic [NUM_CH-1:0] ch_irq_q, ch_irq_d;
  logic              timeout_err_q, timeout_err_d;
  logic              chk_err_q, chk_err_d;

  logic              valid;
  logic [7:0]        rx_byte;
  logic              hdr_match;
  logic              final_byte;
  logic [CH_W-1:0]   ch;
  logic              ch_ok;
  logic              chk_ok;
  logic              expired;

  assign valid      = bus.spi_slave_data_valid;
  assign rx_byte    = bus.spi_slave_byte;
  assign hdr_match  = ((rx_byte & HDR_MASK) == (HDR_VAL & HDR_MASK));
  assign final_byte = (cnt_q == CNT_W'(FRAME_BYTES - 1));
  assign ch         = buf_q[FW-8+CH_LSB +: CH_W];
  assign ch_ok      = (32'(ch) < 32'(NUM_CH));
  assign chk_ok     = !CHK_EN || (rx_byte == xor_q);

  spi_idle_timer #(
    .LIMIT (16'(TIMEOUT_CYCLES))
  ) u_idle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (valid || (state_q == IDLE)),
    .en      (state_q == COLLECT),
    .expired (expired)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    xor_d         = xor_q;
    buf_d         = buf_q;
    frame_data_d  = frame_data_q;
    frame_ch_d    = frame_ch_q;
    frame_valid_d = 1'b0;
    ch_irq_d      = '0;
    timeout_err_d = 1'b0;
    chk_err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid && hdr_match) begin
          buf_d[FW-1 -: 8] = rx_byte;
          xor_d            = rx_byte;
          cnt_d            = CNT_W'(1);
          state_d          = COLLECT;
        end
      end
      COLLECT: begin
        if (valid) begin
          for (int i = 1; i < FRAME_BYTES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
              buf_d[(FRAME_BYTES-1-i)*8 +: 8] = rx_byte;
            end
          end
          xor_d = xor_q ^ rx_byte;
          cnt_d = cnt_q + CNT_W'(1);
          if (final_byte) begin
            state_d = IDLE;
            cnt_d   = '0;
            xor_d   = '0;
            if (ch_ok && chk_ok) begin
              frame_data_d  = buf_d;
              frame_ch_d    = ch;
              frame_valid_d = 1'b1;
              ch_irq_d      = NUM_CH'(1) << ch;
            end else begin
              chk_err_d = 1'b1;
            end
          end
        end else if (expired) begin
          // A byte in the same cycle as expiry keeps the frame alive.
          state_d       = IDLE;
          cnt_d         = '0;
          xor_d         = '0;
          timeout_err_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        xor_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      xor_q         <= '0;
      buf_q         <= '0;
      frame_data_q  <= '0;
      frame_ch_q    <= '0;
      frame_valid_q <= 1'b0;
      ch_irq_q      <= '0;
      timeout_err_q <= 1'b0;
      chk_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      xor_q         <= xor_d;
      buf_q         <= buf_d;
      frame_data_q  <= frame_data_d;
      frame_ch_q    <= frame_ch_d;
      frame_valid_q <= frame_valid_d;
      ch_irq_q      <= ch_irq_d;
      timeout_err_q <= timeout_err_d;
      chk_err_q     <= chk_err_d;
    end
  end

  assign bus.frame_data  = frame_data_q;
  assign bus.frame_ch    = frame_ch_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.ch_irq      = ch_irq_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.chk_err     = chk_err_q;

endmodule

// File: tb/tb_spi_frame_listener.sv
// tb/tb_spi_frame_listener.sv - directed bench for three listener configurations
module tb_spi_frame_listener;

  logic       clk;
  logic       rst_n;
  logic       vld [3];
  logic [7:0] byt [3];

  int checks;
  int errors;
  int fv_cnt [3];
  int ce_cnt [3];
  int to_cnt [3];

  spi_frame_listener_if #(.FRAME_BYTES(3), .NUM_CH(4)) bus0 ();
  spi_frame_listener_if #(.FRAME_BYTES(4), .NUM_CH(4)) bus1 ();
  spi_frame_listener_if #(.FRAME_BYTES(3), .NUM_CH(3)) bus2 ();

  assign bus0.spi_slave_data_valid = vld[0];
  assign bus0.spi_slave_byte       = byt[0];
  assign bus1.spi_slave_data_valid = vld[1];
  assign bus1.spi_slave_byte       = byt[1];
  assign bus2.spi_slave_data_valid = vld[2];
  assign bus2.spi_slave_byte       = byt[2];

  spi_frame_listener u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  spi_frame_listener #(.FRAME_BYTES(4), .CHK_EN(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  spi_frame_listener #(.NUM_CH(3)) u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus0.frame_valid) fv_cnt[0]++;
    if (bus1.frame_valid) fv_cnt[1]++;
    if (bus2.frame_valid) fv_cnt[2]++;
    if (bus0.chk_err) ce_cnt[0]++;
    if (bus1.chk_err) ce_cnt[1]++;
    if (bus2.chk_err) ce_cnt[2]++;
    if (bus0.timeout_err) to_cnt[0]++;
    if (bus1.timeout_err) to_cnt[1]++;
    if (bus2.timeout_err) to_cnt[2]++;
    if ((int'(bus0.frame_valid) + int'(bus0.chk_err) + int'(bus0.timeout_err)) > 1) begin
      errors++;
      $display("FAIL exclusive_pulses u0 got fv=%0b ce=%0b to=%0b required at most one", bus0.frame_valid, bus0.chk_err, bus0.timeout_err);
    end
  end

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin
      fv_cnt[i] = 0;
      ce_cnt[i] = 0;
      to_cnt[i] = 0;
    end
  endtask

  task automatic send(input int d, input logic [7:0] b);
    vld[d] = 1'b1;
    byt[d] = b;
    @(posedge clk);
    #1;
    vld[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    checks++;
    if (bus0.frame_data !== 24'h0 || bus0.frame_ch !== 2'd0 || bus0.frame_valid !== 1'b0 ||
        bus0.ch_irq !== 4'b0 || bus0.timeout_err !== 1'b0 || bus0.chk_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_u0 got fd=%h ch=%0d fv=%0b irq=%b to=%0b ce=%0b required all 0",
               bus0.frame_data, bus0.frame_ch, bus0.frame_valid, bus0.ch_irq, bus0.timeout_err, bus0.chk_err);
    end
    checks++;
    if (bus1.frame_data !== 32'h0 || bus2.frame_data !== 24'h0) begin
      errors++;
      $display("FAIL reset_others got u1=%h u2=%h required 0", bus1.frame_data, bus2.frame_data);
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    send(0, 8'h01); send(0, 8'hAB); send(0, 8'hCD);
    checks++;
    if (bus0.frame_valid !== 1'b1 || bus0.frame_data !== 24'h01ABCD || bus0.frame_ch !== 2'd1 || bus0.ch_irq !== 4'b0010) begin
      errors++;
      $display("FAIL basic_frame got fv=%0b fd=%h ch=%0d irq=%b required 1 01abcd 1 0010",
               bus0.frame_valid, bus0.frame_data, bus0.frame_ch, bus0.ch_irq);
    end
    idle(1);
    checks++;
    if (bus0.frame_valid !== 1'b0 || bus0.ch_irq !== 4'b0 || bus0.frame_data !== 24'h01ABCD) begin
      errors++;
      $display("FAIL basic_one_cycle got fv=%0b irq=%b fd=%h required 0 0000 01abcd", bus0.frame_valid, bus0.ch_irq, bus0.frame_data);
    end
  endtask

  task automatic test_hdr_mismatch();
    clear_counts();
    send(0, 8'h20); send(0, 8'h02); send(0, 8'h11); send(0, 8'h22);
    checks++;
    if (bus0.frame_valid !== 1'b1 || bus0.frame_data !== 24'h021122 || bus0.ch_irq !== 4'b0100) begin
      errors++;
      $display("FAIL mismatch_frame got fv=%0b fd=%h irq=%b required 1 021122 0100", bus0.frame_valid, bus0.frame_data, bus0.ch_irq);
    end
    idle(2);
    checks++;
    if (fv_cnt[0] !== 1 || ce_cnt[0] !== 0) begin
      errors++;
      $display("FAIL mismatch_pulses got fv=%0d ce=%0d required 1 0", fv_cnt[0], ce_cnt[0]);
    end
  endtask

  task automatic test_timeout();
    int hit;
    clear_counts();
    hit = -1;
    send(0, 8'h03); send(0, 8'h55);
    for (int i = 1; i <= 420 && hit < 0; i++) begin
      idle(1);
      if (bus0.timeout_err === 1'b1) hit = i;
    end
    // Counter reaches 400 after 400 idle edges; the abort registers on the next one.
    checks++;
    if (hit != 401) begin
      errors++;
      $display("FAIL timeout_latency got idle_edge=%0d required 401", hit);
    end
    checks++;
    if (bus0.frame_data !== 24'h021122 || bus0.frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_data got fd=%h fv=%0b required 021122 0", bus0.frame_data, bus0.frame_valid);
    end
    send(0, 8'h00); send(0, 8'hAA); send(0, 8'hBB);
    checks++;
    if (bus0.frame_valid !== 1'b1 || bus0.frame_data !== 24'h00AABB || bus0.ch_irq !== 4'b0001) begin
      errors++;
      $display("FAIL after_timeout got fv=%0b fd=%h irq=%b required 1 00aabb 0001", bus0.frame_valid, bus0.frame_data, bus0.ch_irq);
    end
    idle(1);
    checks++;
    if (to_cnt[0] !== 1) begin
      errors++;
      $display("FAIL timeout_count got %0d required 1", to_cnt[0]);
    end
  endtask

  task automatic test_checksum();
    send(1, 8'h03); send(1, 8'h10); send(1, 8'h20); send(1, 8'h33);
    checks++;
    if (bus1.frame_valid !== 1'b1 || bus1.chk_err !== 1'b0 || bus1.frame_data !== 32'h03102033 || bus1.ch_irq !== 4'b1000) begin
      errors++;
      $display("FAIL chk_good got fv=%0b ce=%0b fd=%h irq=%b required 1 0 03102033 1000",
               bus1.frame_valid, bus1.chk_err, bus1.frame_data, bus1.ch_irq);
    end
    send(1, 8'h03); send(1, 8'h10); send(1, 8'h20); send(1, 8'h00);
    checks++;
    if (bus1.chk_err !== 1'b1 || bus1.frame_valid !== 1'b0 || bus1.ch_irq !== 4'b0 || bus1.frame_data !== 32'h03102033) begin
      errors++;
      $display("FAIL chk_bad got ce=%0b fv=%0b irq=%b fd=%h required 1 0 0000 03102033",
               bus1.chk_err, bus1.frame_valid, bus1.ch_irq, bus1.frame_data);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    send(2, 8'h03); send(2, 8'h11); send(2, 8'h22);
    checks++;
    if (bus2.chk_err !== 1'b1 || bus2.frame_valid !== 1'b0 || bus2.frame_data !== 24'h0) begin
      errors++;
      $display("FAIL ch_range got ce=%0b fv=%0b fd=%h required 1 0 000000", bus2.chk_err, bus2.frame_valid, bus2.frame_data);
    end
    send(2, 8'h01); send(2, 8'h33); send(2, 8'h44);
    checks++;
    if (bus2.frame_valid !== 1'b1 || bus2.frame_data !== 24'h013344 || bus2.frame_ch !== 2'd1 || bus2.ch_irq !== 3'b010) begin
      errors++;
      $display("FAIL back_to_back got fv=%0b fd=%h ch=%0d irq=%b required 1 013344 1 010",
               bus2.frame_valid, bus2.frame_data, bus2.frame_ch, bus2.ch_irq);
    end
    idle(1);
  endtask

  task automatic test_reset_midframe();
    send(0, 8'h01); send(0, 8'h02);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus0.frame_data !== 24'h0 || bus0.frame_valid !== 1'b0 || bus0.ch_irq !== 4'b0 || bus0.frame_ch !== 2'd0) begin
      errors++;
      $display("FAIL midframe_reset got fd=%h fv=%0b irq=%b ch=%0d required all 0", bus0.frame_data, bus0.frame_valid, bus0.ch_irq, bus0.frame_ch);
    end
    idle(2);
    rst_n = 1'b1;
    clear_counts();
    send(0, 8'h01); send(0, 8'h02); send(0, 8'h03);
    checks++;
    if (bus0.frame_valid !== 1'b1 || bus0.frame_data !== 24'h010203) begin
      errors++;
      $display("FAIL after_reset_frame got fv=%0b fd=%h required 1 010203", bus0.frame_valid, bus0.frame_data);
    end
    idle(3);
    checks++;
    if (fv_cnt[0] !== 1) begin
      errors++;
      $display("FAIL after_reset_count got %0d required 1", fv_cnt[0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0;
      byt[i] = 8'h00;
    end
    rst_n = 1'b1;
    #2;
    test_reset();
    test_basic();
    test_hdr_mismatch();
    test_timeout();
    test_checksum();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
